// File: rtl/odo_sbox_pkg.sv
// Shared types and constants for the Odo small (6-bit) S-box stage.
package odo_sbox_pkg;

    localparam int ODO_SMALL_W     = 6;
    localparam int ODO_SMALL_DEPTH = 1 << ODO_SMALL_W;

    typedef logic [ODO_SMALL_W-1:0] sbox_small_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        ERR   = 2'd3
    } inv_state_t;

endpackage

// File: rtl/odo_sbox_inv_ram.sv
// DEPTH x W table with one synchronous write port and one registered read port.
module odo_sbox_inv_ram
    import odo_sbox_pkg::*;
#(
    parameter int W     = ODO_SMALL_W,
    parameter int DEPTH = ODO_SMALL_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [W-1:0] raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; it holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/odo_sbox_inv_loader.sv
// Builds the inverse of a streamed forward S-box table, flags duplicates, serves lookups.
module odo_sbox_inv_loader
    import odo_sbox_pkg::*;
#(
    parameter int W     = ODO_SMALL_W,
    parameter int DEPTH = 2 ** W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_start,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    output logic         build_done,
    output logic         build_err,
    input  logic         lk_valid,
    input  logic [W-1:0] lk_in,
    output logic [W-1:0] lk_out,
    output logic         lk_out_valid
);

    inv_state_t       r_state;
    logic [W-1:0]     r_idx;
    logic [DEPTH-1:0] r_seen;
    logic             r_dup;
    logic             r_lk_out_valid;

    logic             w_load_acc;
    logic             w_lk_acc;
    logic             w_dup_now;
    logic             w_last;
    logic [W-1:0]     w_rdata;

    // load_start always wins: it blocks both a same-cycle entry and a same-cycle lookup.
    assign w_load_acc = (r_state == LOAD) && load_valid && !load_start;
    assign w_lk_acc   = (r_state == READY) && lk_valid && !load_start;
    assign w_dup_now  = r_dup || r_seen[load_data];
    assign w_last     = (r_idx == W'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_seen         <= '0;
            r_dup          <= 1'b0;
            r_lk_out_valid <= 1'b0;
        end else begin
            r_lk_out_valid <= w_lk_acc;
            if (load_start) begin
                r_state <= LOAD;
                r_idx   <= '0;
                r_seen  <= '0;
                r_dup   <= 1'b0;
            end else if (w_load_acc) begin
                r_seen[load_data] <= 1'b1;
                r_dup             <= w_dup_now;
                r_idx             <= r_idx + W'(1);
                // DEPTH distinct values fill the bitmap, so no separate permutation check.
                if (w_last) begin
                    r_state <= w_dup_now ? ERR : READY;
                end
            end
        end
    end

    odo_sbox_inv_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_load_acc),
        .waddr (load_data),
        .wdata (r_idx),
        .re    (w_lk_acc),
        .raddr (lk_in),
        .rdata (w_rdata)
    );

    assign load_ready   = (r_state == LOAD);
    assign build_done   = (r_state == READY);
    assign build_err    = (r_state == ERR);
    assign lk_out       = w_rdata;
    assign lk_out_valid = r_lk_out_valid;

endmodule
